regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Shares the single write port of the 16x16-bit register file (rw / RegWrite / WD) between NUM_REQ write requesters, e.g. ALU writeback, load unit and debug. After reset it runs a clear sweep that zeroes every register, then grants requesters round-robin. A lock input lets one requester hold the port for multi-register bursts. All register-file write outputs are registered.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
DW, 16, data width
AW, 4, register address width (2**AW registers)
CLEAR_ON_RESET, 1, 1 = run zero-fill sweep after reset; 0 = go straight to ARB

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_lock  in  NUM_REQ  keep grant after this beat (burst)
req_addr  in  NUM_REQ*AW  packed target register, requester i at [i*AW +: AW]
req_data  in  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
req_ready  out  NUM_REQ  one-hot grant; beat accepted when valid&ready
rf_rw  out  AW  register file write address
rf_we  out  1  register file RegWrite
rf_wd  out  DW  register file write data
grant_id  out  $clog2(NUM_REQ)  index of last accepted requester
init_done  out  1  high once clear sweep finished

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=CLEAR if CLEAR_ON_RESET, else ARB.
  - rf_we=0, rf_rw=0, rf_wd=0, req_ready=0, grant_id=0.
  - init_done = !CLEAR_ON_RESET.
  - rr pointer = 0, clear counter = 0.
- CLEAR:
  - Each cycle: rf_we=1, rf_wd=0, rf_rw=counter, counter++.
  - After the write of address 2**AW-1 (16 cycles): init_done=1, go to ARB.
  - req_ready=0 throughout.
- ARB:
  - req_ready is combinational.
  - Search starts at rr pointer and wraps modulo NUM_REQ; the first requester with req_valid=1 gets req_ready=1. Exactly one bit is high, or none.
  - On accept from requester i, the next cycle shows rf_we=1, rf_rw=req_addr[i], rf_wd=req_data[i], grant_id=i. Latency is one cycle.
  - On accept, rr pointer = (i+1) mod NUM_REQ.
  - If req_lock[i]=1 on the accepted beat, go to LOCK(i).
  - No accept in a cycle: rf_we=0 next cycle; rf_rw and rf_wd hold their last value.
- LOCK(i):
  - req_ready=onehot(i) only; other requesters stall.
  - Each valid beat writes as in ARB.
  - A valid beat with req_lock[i]=0 ends the burst and returns to ARB.
  - A cycle with req_valid[i]=0 holds LOCK and produces no write.
  - rr pointer frozen at (i+1) mod NUM_REQ.
- Throughput: one write per cycle sustained, including back-to-back beats from different requesters.
- Same address from consecutive beats: later beat wins, written in order. No merging.
- Reset asserted mid-burst or mid-clear: immediate return to the reset state. The sweep restarts at address 0 after release.
- req_lock sampled only on accepted beats. req_lock without req_valid is ignored.
- Requester contract: addr and data must be stable while valid and not ready.

Optional Feature:
REGFILE_ARB_STATS_EN
- Defined:
  - Adds output stat_grants (NUM_REQ*16 bits): per-requester 16-bit saturating accept counters.
  - Adds output stat_stalls (16 bits): saturating count of cycles in ARB or LOCK with at least one req_valid whose req_ready=0.
  - Both counters clear on reset; they do not count during CLEAR.
- Undefined: the ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, no requests -> rf_we=1 for exactly 16 cycles, rf_rw=0..15, rf_wd=0; init_done rises after rf_rw=15; req_ready=0 during sweep.
- After init, req0 valid addr=4'hF data=16'hDADA -> req_ready[0]=1 same cycle; next cycle rf_we=1, rf_rw=F, rf_wd=DADA, grant_id=0.
- All three valid continuously, no lock, pointer at 0 -> grant order 0,1,2,0,1,2, one write per cycle, rf_rw tracks each requester's addr.
- req1 burst: lock=1 on addrs 2,3, lock=0 on addr 4, with req0/req2 valid throughout -> only req_ready[1] for 3 beats; next grant goes to req2.
- rst_n pulsed low while in LOCK during a write -> rf_we=0 and req_ready=0 asynchronously; after release, a fresh 16-cycle sweep runs from address 0.
- With REGFILE_ARB_STATS_EN: req0 and req1 both valid for 4 cycles -> stat_grants requester 0 = 2, requester 1 = 2, stat_stalls = 4.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 16x16 register file: zero-fill sweep after reset, then round-robin grants with lockable bursts.
// Optional REGFILE_ARB_STATS_EN adds per-requester accept counters and a stall counter.
module regfile_wr_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int DW             = 16,
   parameter int AW             = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_lock,
   input  logic [NUM_REQ*AW-1:0]      req_addr,
   input  logic [NUM_REQ*DW-1:0]      req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [AW-1:0]              rf_rw,
   output logic                       rf_we,
   output logic [DW-1:0]              rf_wd,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       init_done
`ifdef REGFILE_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]      stat_grants,
   output logic [15:0]                stat_stalls
`endif
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_ARB   = 2'd1,
      S_LOCK  = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_next_s;
   logic [AW-1:0]        clr_cnt_r;
   logic [IW-1:0]        rr_r;
   logic [IW-1:0]        lock_id_r;
   logic [NUM_REQ-1:0]   ready_s;
   logic                 accept_s;
   logic [IW-1:0]        acc_idx_s;
   logic [IW-1:0]        rr_next_s;
   logic [IW-1:0]        pick_s;
   logic                 found_s;
   logic [IW:0]          cand_s;
   logic [IW:0]          inc_s;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = {{(NUM_REQ-1){1'b0}}, 1'b1};
      return v << idx;
   endfunction

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      found_s = 1'b0;
      pick_s  = '0;
      cand_s  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = {1'b0, rr_r} + (IW+1)'(k);
         if (cand_s >= NREQ_W) begin
            cand_s = cand_s - NREQ_W;
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req_valid[cand_s[IW-1:0]]) begin
            found_s = 1'b1;
            pick_s  = cand_s[IW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state, grant vector and accept decode.
   always_comb begin
      state_next_s = state_r;
      ready_s      = '0;
      accept_s     = 1'b0;
      acc_idx_s    = pick_s;
      case (state_r)
         S_CLEAR: begin
            if (&clr_cnt_r) begin
               state_next_s = S_ARB;
            end else begin
               state_next_s = S_CLEAR;
            end
         end
         S_ARB: begin
            ready_s   = found_s ? onehot(pick_s) : '0;
            accept_s  = found_s;
            acc_idx_s = pick_s;
            if (found_s && req_lock[pick_s]) begin
               state_next_s = S_LOCK;
            end else begin
               state_next_s = S_ARB;
            end
         end
         S_LOCK: begin
            ready_s   = onehot(lock_id_r);
            accept_s  = req_valid[lock_id_r];
            acc_idx_s = lock_id_r;
            if (accept_s && !req_lock[lock_id_r]) begin
               state_next_s = S_ARB;
            end else begin
               state_next_s = S_LOCK;
            end
         end
         default: begin
            state_next_s = CLEAR_ON_RESET ? S_CLEAR : S_ARB;
         end
      endcase
   end

   // Pointer advance past the accepted requester.
   always_comb begin
      inc_s = {1'b0, acc_idx_s} + {{IW{1'b0}}, 1'b1};
      if (inc_s >= NREQ_W) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = inc_s[IW-1:0];
      end
   end

   // Grants drop immediately while reset is asserted, whatever the state encoding.
   assign req_ready = rst_n ? ready_s : '0;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CLEAR_ON_RESET ? S_CLEAR : S_ARB;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Registered write port, sweep counter, pointer and lock owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we     <= 1'b0;
         rf_rw     <= '0;
         rf_wd     <= '0;
         grant_id  <= '0;
         init_done <= !CLEAR_ON_RESET;
         rr_r      <= '0;
         clr_cnt_r <= '0;
         lock_id_r <= '0;
      end else begin
         case (state_r)
            S_CLEAR: begin
               rf_we     <= 1'b1;
               rf_rw     <= clr_cnt_r;
               rf_wd     <= '0;
               clr_cnt_r <= clr_cnt_r + AW'(1);
               if (&clr_cnt_r) begin
                  init_done <= 1'b1;
               end
            end
            S_ARB, S_LOCK: begin
               rf_we <= accept_s;
               if (accept_s) begin
                  rf_rw     <= req_addr[acc_idx_s*AW +: AW];
                  rf_wd     <= req_data[acc_idx_s*DW +: DW];
                  grant_id  <= acc_idx_s;
                  rr_r      <= rr_next_s;
                  lock_id_r <= acc_idx_s;
               end
            end
            default: begin
               rf_we <= 1'b0;
            end
         endcase
      end
   end

`ifdef REGFILE_ARB_STATS_EN
   logic [15:0] grant_cnt_r [NUM_REQ];
   logic [15:0] stall_cnt_r;
   logic        stall_s;

   assign stall_s = ((state_r == S_ARB) || (state_r == S_LOCK)) && (|(req_valid & ~ready_s));

   // Saturating statistics; idle during the sweep because accept_s and stall_s are low there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_r[i] <= 16'h0000;
         end
         stall_cnt_r <= 16'h0000;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_s && (acc_idx_s == IW'(i)) && (grant_cnt_r[i] != 16'hFFFF)) begin
               grant_cnt_r[i] <= grant_cnt_r[i] + 16'h0001;
            end
         end
         if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_grants[g*16 +: 16] = grant_cnt_r[g];
   end
   assign stat_stalls = stall_cnt_r;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: reference model predicts grants and writes, a monitor checks them.
module tb_regfile_wr_arbiter;
   localparam int N  = 3;
   localparam int DW = 16;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_lock;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic [AW-1:0]   rf_rw;
   logic            rf_we;
   logic [DW-1:0]   rf_wd;
   logic [1:0]      grant_id;
   logic            init_done;
`ifdef REGFILE_ARB_STATS_EN
   logic [N*16-1:0] stat_grants;
   logic [15:0]     stat_stalls;
`endif

   regfile_wr_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
      .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .rf_rw(rf_rw), .rf_we(rf_we), .rf_wd(rf_wd), .grant_id(grant_id),
      .init_done(init_done)
`ifdef REGFILE_ARB_STATS_EN
      , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            id;
      bit            is_clear;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   rr_m, lk_m, clear_left;
   bit   exp_init;

   logic          pv [N];
   logic          pl [N];
   logic [AW-1:0] pa [N];
   logic [DW-1:0] pd [N];
   int            burst_k;
   bit            single_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor + reference model: the model decides each cycle's grant from the rules, the DUT must match.
   initial begin : monitor
      logic [N-1:0] er;
      logic [N-1:0] acc;
      exp_t         e;
      int           idx;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            rr_m = 0; lk_m = -1; clear_left = 16; exp_init = 1'b0;
            chk("rst_we", 32'(rf_we), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_grant_id", 32'(grant_id), 32'd0);
            chk("rst_init_done", 32'(init_done), 32'd0);
         end else begin
            chk("we", 32'(rf_we), 32'(q.size() != 0));
            if (q.size() != 0) begin
               e = q.pop_front();
               if (rf_we) begin
                  chk("rw", 32'(rf_rw), 32'(e.addr));
                  chk("wd", 32'(rf_wd), 32'(e.data));
                  if (!e.is_clear) chk("grant_id", 32'(grant_id), 32'(e.id));
               end
               if (e.is_clear && e.addr == 4'hF) exp_init = 1'b1;
            end
            chk("init_done", 32'(init_done), 32'(exp_init));
            er = '0;
            if (clear_left > 0) begin
               er = '0;
            end else if (lk_m >= 0) begin
               er[lk_m] = 1'b1;
            end else begin
               for (int k = 0; k < N; k++) begin
                  if (er == '0 && req_valid[(rr_m + k) % N]) er[(rr_m + k) % N] = 1'b1;
               end
            end
            chk("ready", 32'(req_ready), 32'(er));
            if (clear_left > 0) begin
               e.addr = 4'(16 - clear_left); e.data = 16'h0000; e.id = 0; e.is_clear = 1'b1;
               q.push_back(e);
               clear_left--;
            end else begin
               acc = req_valid & er;
               if (acc != '0) begin
                  idx = 0;
                  for (int k = 0; k < N; k++) if (acc[k]) idx = k;
                  e.addr = req_addr[idx*AW +: AW]; e.data = req_data[idx*DW +: DW];
                  e.id = idx; e.is_clear = 1'b0;
                  q.push_back(e);
                  rr_m = (idx + 1) % N;
                  lk_m = req_lock[idx] ? idx : -1;
               end
            end
         end
      end
   end

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = pv[i];
         req_lock[i]  = pl[i];
         req_addr[i*AW +: AW] = pa[i];
         req_data[i*DW +: DW] = pd[i];
      end
   endtask

   // Modes: 0 random, 1 all valid unlocked, 2 req1 burst, 3 idle, 4 single req0 beat, 6 req0/req1 valid.
   task automatic refill(input int i, input int mode);
      pa[i] = 4'($urandom);
      pd[i] = 16'($urandom);
      pl[i] = 1'b0;
      pv[i] = 1'b0;
      case (mode)
         0: begin
            pv[i] = ($urandom_range(0, 9) < 6);
            pl[i] = ($urandom_range(0, 3) == 0);
         end
         1: pv[i] = 1'b1;
         2: begin
            if (i != 1) begin
               pv[i] = 1'b1;
            end else if (burst_k < 3) begin
               pv[i] = 1'b1;
               pa[i] = 4'(2 + burst_k);
               pl[i] = (burst_k < 2);
               burst_k++;
            end
         end
         4: begin
            if (i == 0 && !single_done) begin
               pv[i] = 1'b1; pa[i] = 4'hF; pd[i] = 16'hDADA; single_done = 1'b1;
            end
         end
         6: pv[i] = (i < 2);
         default: pv[i] = 1'b0;
      endcase
   endtask

   task automatic step(input int mode);
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] || !pv[i] || mode == 3) refill(i, mode);
      end
      drive();
   endtask

   initial begin : stimulus
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         pv[i] = 1'b0; pl[i] = 1'b0; pa[i] = '0; pd[i] = '0;
      end
      drive();
      burst_k = 0; single_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) step(3);
      repeat (4) step(4);
      repeat (2) step(3);
      repeat (8) step(1);
      repeat (2) step(3);
      burst_k = 0;
      repeat (10) step(2);
      repeat (2) step(3);
      repeat (400) step(0);
      repeat (8) step(1);
      repeat (2) step(3);

      // Reset asserted while a locked burst beat is being written.
      @(posedge clk); #1;
      pv[1] = 1'b1; pl[1] = 1'b1; pa[1] = 4'h7; pd[1] = 16'h1234;
      drive();
      @(posedge clk); #1;
      chk("lock_write_before_rst", 32'(rf_we), 32'd1);
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         pv[i] = 1'b0; pl[i] = 1'b0;
      end
      drive();
      #1;
      chk("async_rst_we", 32'(rf_we), 32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (18) step(3);

`ifdef REGFILE_ARB_STATS_EN
      repeat (4) step(6);
      step(3);
      chk("stat_grants0", 32'(stat_grants[15:0]), 32'd2);
      chk("stat_grants1", 32'(stat_grants[31:16]), 32'd2);
      chk("stat_grants2", 32'(stat_grants[47:32]), 32'd0);
      chk("stat_stalls", 32'(stat_stalls), 32'd4);
`endif

      repeat (3) step(3);
      chk("drain", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
